// File: rtl/sc_mul_rr_scheduler_if.sv
// rtl/sc_mul_rr_scheduler_if.sv - request, multiplier and response bundle for the shared SC multiplier scheduler
interface sc_mul_rr_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;
    logic                          mul_start;
    logic [2*DATA_WIDTH-1:0]       mul_result;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [2*DATA_WIDTH-1:0]       rsp_result;
    logic                          busy;

    modport master (
        output req_valid, req_a, req_b, mul_result, rsp_ready,
        input  req_ready, mul_a, mul_b, mul_start, rsp_valid, rsp_id, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_result, rsp_ready,
        output req_ready, mul_a, mul_b, mul_start, rsp_valid, rsp_id, rsp_result, busy
    );
endinterface

// File: rtl/sc_mul_rr_scheduler.sv
// rtl/sc_mul_rr_scheduler.sv - round-robin sharing of one multi-cycle SC multiplier among NUM_REQ requesters
module sc_mul_rr_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int MUL_LATENCY = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    sc_mul_rr_scheduler_if.slave     bus
);
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] winner;
    logic            found;
    logic [CNT_W-1:0] cnt;
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] scan_idx;

    // Scan from farthest to nearest so the nearest valid requester after last wins.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_sum = {1'b0, last} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (bus.req_valid[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found && !rst) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last           <= ID_W'(NUM_REQ - 1);
            cnt            <= '0;
            bus.mul_a      <= '0;
            bus.mul_b      <= '0;
            bus.mul_start  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
            bus.busy       <= 1'b0;
        end else begin
            bus.mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.mul_a     <= bus.req_a[winner*DATA_WIDTH +: DATA_WIDTH];
                        bus.mul_b     <= bus.req_b[winner*DATA_WIDTH +: DATA_WIDTH];
                        bus.rsp_id    <= winner;
                        last          <= winner;
                        cnt           <= CNT_W'(MUL_LATENCY);
                        bus.mul_start <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    // Operands have now been held for MUL_LATENCY cycles.
                    if (cnt == CNT_W'(1)) begin
                        bus.rsp_result <= bus.mul_result;
                        bus.rsp_valid  <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_mul_rr_scheduler.sv
// tb/tb_sc_mul_rr_scheduler.sv - directed bench with a transaction-level model of the SC multiplier scheduler
module tb_sc_mul_rr_scheduler;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int L  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_mul_rr_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_W(IW)) bus();

    sc_mul_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_W(IW), .MUL_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Multiplier: exact product once operands have been held L cycles, garbage before.
    int mage = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) mage <= 0;
        else if (bus.mul_start) mage <= 1;
        else if (mage < 1000) mage <= mage + 1;
    end
    assign bus.mul_result = (!bus.mul_start && mage >= L - 1) ?
                            ({16'b0, bus.mul_a} * {16'b0, bus.mul_b}) : 32'hA5A5_5A5A;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    function automatic logic [N-1:0] exp_ready(input logic [N-1:0] v, input int last, input int age);
        int w;
        exp_ready = '0;
        w = rr_pick(v, last);
        if (age == 0 && w >= 0) exp_ready[w] = 1'b1;
    endfunction

    // Model: m_age counts cycles since acceptance (0 = idle, L+1 = response pending).
    int              m_age  = 0;
    int              m_last = N - 1;
    int              m_id   = 0;
    logic [DW-1:0]   m_a    = '0;
    logic [DW-1:0]   m_b    = '0;
    logic [2*DW-1:0] m_res  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age <= 0; m_last <= N - 1; m_id <= 0;
            m_a <= '0; m_b <= '0; m_res <= '0;
        end else if (m_age == 0) begin
            if (rr_pick(bus.req_valid, m_last) >= 0) begin
                m_age  <= 1;
                m_id   <= rr_pick(bus.req_valid, m_last);
                m_last <= rr_pick(bus.req_valid, m_last);
                m_a    <= slice(bus.req_a, rr_pick(bus.req_valid, m_last));
                m_b    <= slice(bus.req_b, rr_pick(bus.req_valid, m_last));
            end
        end else if (m_age <= L) begin
            m_age <= m_age + 1;
            if (m_age == L) m_res <= {16'b0, m_a} * {16'b0, m_b};
        end else if (bus.rsp_ready) begin
            m_age <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_ready",  64'(bus.req_ready),  64'(0));
            check("rst_mul_a",      64'(bus.mul_a),      64'(0));
            check("rst_mul_b",      64'(bus.mul_b),      64'(0));
            check("rst_mul_start",  64'(bus.mul_start),  64'(0));
            check("rst_rsp_valid",  64'(bus.rsp_valid),  64'(0));
            check("rst_rsp_id",     64'(bus.rsp_id),     64'(0));
            check("rst_rsp_result", 64'(bus.rsp_result), 64'(0));
            check("rst_busy",       64'(bus.busy),       64'(0));
        end else begin
            check("req_ready",  64'(bus.req_ready),  64'(exp_ready(bus.req_valid, m_last, m_age)));
            check("mul_start",  64'(bus.mul_start),  64'(m_age == 1));
            check("busy",       64'(bus.busy),       64'(m_age != 0));
            check("rsp_valid",  64'(bus.rsp_valid),  64'(m_age == L + 1));
            check("mul_a",      64'(bus.mul_a),      64'(m_a));
            check("mul_b",      64'(bus.mul_b),      64'(m_b));
            check("rsp_id",     64'(bus.rsp_id),     64'(m_id));
            check("rsp_result", 64'(bus.rsp_result), 64'(m_res));
        end
    end

    int              g_cyc[$];
    int              g_id[$];
    int              r_cyc[$];
    int              r_id[$];
    logic [2*DW-1:0] r_res[$];
    int              s_cyc[$];
    int              ready_during_rsp = 0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i]) begin
                    g_cyc.push_back(cycle);
                    g_id.push_back(i);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                r_cyc.push_back(cycle);
                r_id.push_back(int'(bus.rsp_id));
                r_res.push_back(bus.rsp_result);
            end
            if (bus.mul_start) s_cyc.push_back(cycle);
            if (bus.rsp_valid && |bus.req_ready) ready_during_rsp++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_valid[i]      = 1'b1;
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int target, input bit drop);
        int k = 0;
        while (g_id.size() < target && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (g_id.size() < target) begin
            check("grant_timeout", 64'(0), 64'(1));
        end else begin
            @(posedge clk); #1;
            if (drop) bus.req_valid[g_id[target-1]] = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int target);
        int k = 0;
        while (r_id.size() < target && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (r_id.size() < target) check("rsp_timeout", 64'(0), 64'(1));
        else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.rsp_valid && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (!bus.rsp_valid) check("valid_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int gb;
        int rb;
        int sb;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset: no grant even with every requester valid.
        tick(2);
        bus.req_valid = '1;
        @(negedge clk); #1;
        check("ready_in_reset", 64'(bus.req_ready), 64'(0));
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst = 1'b0;

        // Single request from requester 0.
        gb = g_id.size(); rb = r_id.size(); sb = s_cyc.size();
        set_req(0, 16'd11, 16'd12);
        wait_grant(gb + 1, 1'b1);
        wait_rsp(rb + 1);
        check("t1_grant_id",  64'(g_id[gb]), 64'(0));
        check("t1_start_lat", 64'(s_cyc[sb] - g_cyc[gb]), 64'(1));
        check("t1_rsp_lat",   64'(r_cyc[rb] - g_cyc[gb]), 64'(17));
        check("t1_result",    64'(r_res[rb]), 64'(132));
        check("t1_rsp_id",    64'(r_id[rb]), 64'(0));

        // All four requesters continuously valid from a fresh pointer.
        do_reset();
        gb = g_id.size(); rb = r_id.size();
        for (int i = 0; i < N; i++) set_req(i, 16'((i + 1) * 100), 16'(i + 2));
        wait_grant(gb + 5, 1'b0);
        bus.req_valid = '0;
        wait_rsp(rb + 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_grant_order", 64'(g_id[gb+i]), 64'(i % 4));
            check("t2_rsp_order",   64'(r_id[rb+i]), 64'(i % 4));
        end
        for (int i = 1; i < 5; i++) check("t2_spacing", 64'(g_cyc[gb+i] - g_cyc[gb+i-1]), 64'(18));
        check("t2_result0", 64'(r_res[rb]),   64'(200));
        check("t2_result4", 64'(r_res[rb+4]), 64'(200));

        // Backpressure: response held 10 cycles, requester 2 pending throughout.
        gb = g_id.size(); rb = r_id.size();
        bus.rsp_ready = 1'b0;
        set_req(1, 16'd3, 16'd5);
        set_req(2, 16'd7, 16'd9);
        wait_grant(gb + 1, 1'b1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_result", 64'(bus.rsp_result), 64'(15));
            check("t3_hold_id",     64'(bus.rsp_id),     64'(1));
            check("t3_no_ready",    64'(bus.req_ready),  64'(0));
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_grant(gb + 2, 1'b1);
        wait_rsp(rb + 2);
        check("t3_first_id",   64'(g_id[gb]),   64'(1));
        check("t3_next_id",    64'(g_id[gb+1]), 64'(2));
        check("t3_next_grant", 64'(g_cyc[gb+1] - r_cyc[rb]), 64'(1));
        check("t3_result2",    64'(r_res[rb+1]), 64'(63));

        // Boundary operands.
        rb = r_id.size(); gb = g_id.size();
        set_req(0, 16'hFFFF, 16'hFFFF);
        wait_grant(gb + 1, 1'b1);
        wait_rsp(rb + 1);
        check("t4_max_result", 64'(r_res[rb]), 64'h0000_0000_FFFE_0001);
        set_req(3, 16'h0000, 16'h1234);
        wait_grant(gb + 2, 1'b1);
        wait_rsp(rb + 2);
        check("t4_zero_result", 64'(r_res[rb+1]), 64'(0));
        check("t4_zero_id",     64'(r_id[rb+1]),  64'(3));

        // Reset during RUN cycle 5 discards the operation and restores priority.
        gb = g_id.size();
        set_req(1, 16'h55, 16'h66);
        wait_grant(gb + 1, 1'b1);
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        check("t5_mul_a",      64'(bus.mul_a),      64'(0));
        check("t5_mul_b",      64'(bus.mul_b),      64'(0));
        check("t5_rsp_id",     64'(bus.rsp_id),     64'(0));
        check("t5_busy",       64'(bus.busy),       64'(0));
        check("t5_rsp_valid",  64'(bus.rsp_valid),  64'(0));
        check("t5_rsp_result", 64'(bus.rsp_result), 64'(0));
        rb = r_id.size(); gb = g_id.size();
        set_req(2, 16'h20, 16'h30);
        set_req(3, 16'h40, 16'h50);
        tick(2);
        rst = 1'b0;
        wait_grant(gb + 1, 1'b1);
        wait_grant(gb + 2, 1'b1);
        wait_rsp(rb + 2);
        check("t5_first_grant",  64'(g_id[gb]),    64'(2));
        check("t5_second_grant", 64'(g_id[gb+1]),  64'(3));
        check("t5_rsp0_id",      64'(r_id[rb]),    64'(2));
        check("t5_rsp0_result",  64'(r_res[rb]),   64'(16'h0600));
        check("t5_rsp1_result",  64'(r_res[rb+1]), 64'(16'h1400));

        // Wrap-around from last=3 with requesters 1 and 3 valid.
        rb = r_id.size(); gb = g_id.size();
        set_req(1, 16'd7, 16'd8);
        set_req(3, 16'd9, 16'd10);
        wait_grant(gb + 1, 1'b1);
        wait_grant(gb + 2, 1'b1);
        wait_rsp(rb + 2);
        check("t6_first_grant",  64'(g_id[gb]),    64'(1));
        check("t6_second_grant", 64'(g_id[gb+1]),  64'(3));
        check("t6_result1",      64'(r_res[rb]),   64'(56));
        check("t6_result3",      64'(r_res[rb+1]), 64'(90));

        check("ready_during_rsp", 64'(ready_during_rsp), 64'(0));
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
